// File: rtl/alu_seq.sv
// alu_seq: sequential integer ALU with a valid/ready front end and a
// valid/ready result port. Add, sub and mul finish in a single cycle.
// Divide uses an iterative restoring divider that works on operand
// magnitudes and produces one quotient bit per cycle.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand/op bundle valid
//   in_ready   high only in IDLE; a bundle is taken when in_valid & in_ready
//   a, b       operands (WIDTH bits)
//   op         one-hot op: 0001 add, 0010 sub, 0100 mul, 1000 div
//   sgn        1 = two's-complement signed, 0 = unsigned
//   out_valid  result bundle valid; held until out_ready
//   out_ready  consumer accepts the result
//   y          result
//   overflow   result does not fit in WIDTH bits
//   dz         divide by zero
//   err        invalid op code was accepted
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a bundle; in_ready = 1
// DIV   | restoring divider iterating, one quotient bit per cycle
// DONE  | result presented on y/flags with out_valid = 1
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             dz,
  output logic             err
);

  // The divider always runs one iteration per operand bit.
  localparam int DIV_CYCLES = WIDTH;
  localparam int CW         = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Single-cycle datapath, evaluated on the live inputs at accept time.
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               mul_ovf_s;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign diff    = a - b;

  // Sign- or zero-extending to 2*WIDTH lets one truncated multiplier
  // produce the correct full product for both signed and unsigned modes.
  assign ext_a = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign ext_b = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod  = ext_a * ext_b;

  // Signed product fits only if the top WIDTH+1 bits are a pure sign run.
  assign mul_ovf_s = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));

  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  // One restoring-division step. The dividend is shifted out of the top of
  // quo_q while quotient bits shift in at the bottom.
  logic [WIDTH:0]   shl, trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nx, quo_nx, quo_final;
  logic             div_ovf;

  assign shl    = {rem_q, quo_q[WIDTH-1]};
  assign trial  = shl - {1'b0, dvsr_q};
  assign fits   = !trial[WIDTH];
  assign rem_nx = fits ? trial[WIDTH-1:0] : shl[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], fits};

  assign quo_final = neg_q ? -quo_nx : quo_nx;
  // A positive signed quotient with the MSB set can only be
  // -2^(WIDTH-1) / -1; its bit pattern already equals the required y.
  assign div_ovf   = sgn_q && !neg_q && quo_nx[WIDTH-1];

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    err_d   = err_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          err_d   = 1'b0;
          case (op)
            4'b0001: begin
              y_d   = sum_ext[WIDTH-1:0];
              ovf_d = sgn ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]))
                          : sum_ext[WIDTH];
            end
            4'b0010: begin
              y_d   = diff;
              ovf_d = sgn ? ((a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]))
                          : (a < b);
            end
            4'b0100: begin
              y_d   = prod[WIDTH-1:0];
              ovf_d = sgn ? mul_ovf_s : (|prod[2*WIDTH-1:WIDTH]);
            end
            4'b1000: begin
              if (b == '0) begin
                y_d  = '0;
                dz_d = 1'b1;
              end else begin
                state_d = S_DIV;
                rem_d   = '0;
                quo_d   = a_mag;
                dvsr_d  = b_mag;
                neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                sgn_d   = sgn;
                cnt_d   = CW'(DIV_CYCLES - 1);
              end
            end
            default: begin
              // y keeps the previous result
              err_d = 1'b1;
            end
          endcase
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          y_d     = quo_final;
          ovf_d   = div_ovf;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign overflow  = ovf_q;
  assign dz        = dz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): directed and random bundles, expected
// results from an arithmetic reference model queued at accept time and
// checked by an independent monitor when results are handed over.
module tb_alu_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint unsigned UMAXU = 64'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b, y;
  logic [3:0]    op;
  logic          sgn;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow, dz, err;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .overflow(overflow), .dz(dz), .err(err)
  );

  typedef struct {
    logic [W-1:0] y;
    bit           ovf;
    bit           dz;
    bit           err;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         scb[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  logic [W-1:0] last_y = '0;
  int           bp_req = 0;
  bit           rand_bp = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [3:0] iop, input bit is);
    exp_t e;
    longint sa, sbv, r;
    longint unsigned ua, ub, pu;
    sa  = $signed(ia);
    sbv = $signed(ib);
    ua  = {32'b0, ia};
    ub  = {32'b0, ib};
    e.y = last_y; e.ovf = 0; e.dz = 0; e.err = 0; e.acc = 0; e.lat = 1;
    case (iop)
      4'b0001: if (is) begin r = sa + sbv; e.y = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
               else begin pu = ua + ub; e.y = pu[31:0]; e.ovf = pu > UMAXU; end
      4'b0010: if (is) begin r = sa - sbv; e.y = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
               else begin e.y = ia - ib; e.ovf = ua < ub; end
      4'b0100: if (is) begin r = sa * sbv; e.y = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
               else begin pu = ua * ub; e.y = pu[31:0]; e.ovf = pu > UMAXU; end
      4'b1000: begin
        if (ib == 0) begin
          e.y = '0; e.dz = 1;
        end else begin
          e.lat = W + 1;
          if (is) begin
            if (sa == SMIN && sbv == -1) begin e.y = 32'h80000000; e.ovf = 1; end
            else begin r = sa / sbv; e.y = r[31:0]; end
          end else begin
            pu = ua / ub; e.y = pu[31:0];
          end
        end
      end
      default: e.err = 1;
    endcase
    last_y = e.y;
    return e;
  endfunction

  // Called just after a negedge; returns just after the negedge following accept.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [3:0] iop, input bit is);
    exp_t e;
    int n = 0;
    in_valid = 1'b1; a = ia; b = ib; op = iop; sgn = is;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    e = model(ia, ib, iop, is);
    e.acc = cyc + 1;
    scb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom); sgn = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((scb.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", scb.size());
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(7))
      0: return 32'h00000000;
      1: return 32'h00000001;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] v;
    case ($urandom_range(9))
      0, 1: return 4'b0001;
      2, 3: return 4'b0010;
      4, 5: return 4'b0100;
      6, 7: return 4'b1000;
      default: begin
        v = 4'($urandom);
        while ($countones(v) == 1) v = 4'($urandom);
        return v;
      end
    endcase
  endfunction

  // Monitor: decides out_ready itself and checks each handed-over result.
  bit           seen = 1'b0;
  int           first = 0;
  int           hold = 0;
  logic [W-1:0] snap_y;
  logic [2:0]   snap_f;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      seen = 1'b0; hold = 0; out_ready = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1; first = cyc; snap_y = y; snap_f = {overflow, dz, err};
        hold = bp_req; bp_req = 0;
      end else begin
        check("hold_y", y, snap_y);
        check("hold_flags", {overflow, dz, err}, snap_f);
      end
      if (hold > 0) begin
        hold--;
        out_ready = 1'b0;
        check("stall_in_ready", in_ready, 1'b0);
      end else if (rand_bp && $urandom_range(3) == 0) begin
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
        seen = 1'b0;
        if (scb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got y=%0h with no pending operation", y);
        end else begin
          e = scb.pop_front();
          check("y", y, e.y);
          check("overflow", overflow, e.ovf);
          check("dz", dz, e.dz);
          check("err", err, e.err);
          check("latency", 64'(first - e.acc + 1), 64'(e.lat));
        end
      end
    end else begin
      out_ready = 1'b1;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; sgn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, 32'h0);
    check("rst_flags", {overflow, dz, err}, 3'b000);
    rst = 1'b0;
    last_y = '0;
    @(negedge clk);

    issue(32'hFFFFFFFF, 32'h1, 4'b0001, 1'b0);
    issue(32'hFFFFFFFF, 32'h1, 4'b0001, 1'b1);
    issue(32'hFFFFFFFD, 32'h7, 4'b0100, 1'b1);
    issue(32'h00010000, 32'h00010000, 4'b0100, 1'b0);
    issue(32'hFFFFFFF9, 32'h2, 4'b1000, 1'b1);
    issue(32'h80000000, 32'hFFFFFFFF, 4'b1000, 1'b1);
    issue(32'h5, 32'h0, 4'b1000, 1'b0);
    issue(32'h0, 32'h0, 4'b0011, 1'b0);
    issue(32'h1, 32'h2, 4'b0001, 1'b0);
    issue(32'h7, 32'h7, 4'b0011, 1'b1);
    issue(32'h3, 32'h5, 4'b0010, 1'b0);
    issue(32'h80000000, 32'h1, 4'b0010, 1'b1);
    drain();

    // Backpressure with inputs wiggling while the result is held.
    bp_req = 10;
    issue(32'h12345678, 32'h11111111, 4'b0001, 1'b0);
    repeat (8) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; op = 4'b0001; sgn = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();

    // Reset five cycles into a divide.
    issue(32'd100, 32'd7, 4'b1000, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    scb.delete();
    last_y = '0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_y", y, 32'h0);
    issue(32'd2, 32'd3, 4'b0001, 1'b0);
    drain();
    repeat (40) @(negedge clk);

    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(rand_operand(), rand_operand(), rand_op(), 1'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
